// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream
//   Streams one-hot words back into binary indices. Each accepted word is
//   encoded to the index of its lowest set bit, flagged as malformed when it
//   is not exactly one-hot, and queued in a 2-entry FIFO.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   upstream word valid
//   in_ready   block can accept a word (depends only on state and rst)
//   in_vec     one-hot input word, IN_BITS wide
//   out_valid  head-of-buffer result valid
//   out_ready  downstream accepts result
//   out_idx    binary index of head result (0 when out_valid=0)
//   out_err    head result came from a malformed word (0 when out_valid=0)
//   err_clr    synchronous clear of err_cnt
//   err_cnt    saturating count of malformed words accepted
module onehot_encoder_stream #(
    parameter  int unsigned BITS    = 3,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned IN_BITS = 1 << BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_BITS-1:0] in_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITS-1:0]    out_idx,
    output logic               out_err,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [IN_BITS-1:0] VecOne = {{(IN_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // FIFO state: slot "head" is presented on the outputs, "tail" is behind it.
    logic [1:0]       cnt_q, cnt_d;
    logic [BITS-1:0]  head_idx_q, head_idx_d;
    logic             head_err_q, head_err_d;
    logic [BITS-1:0]  tail_idx_q, tail_idx_d;
    logic             tail_err_q, tail_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [BITS-1:0]  enc_idx;
    logic             enc_err;
    logic             found;
    logic             push;
    logic             pop;

    // Lowest-set-bit priority encoder plus malformed detection.
    // A word is malformed when it is zero or has more than one bit set;
    // v & (v - 1) clears the lowest set bit, so nonzero means popcount > 1.
    always_comb begin
        enc_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < IN_BITS; i++) begin
            if (in_vec[i] && !found) begin
                enc_idx = BITS'(i);
                found   = 1'b1;
            end
        end
        enc_err = (in_vec == '0) || ((in_vec & (in_vec - VecOne)) != '0);
    end

    assign in_ready  = !rst && (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_idx   = out_valid ? head_idx_q : '0;
    assign out_err   = out_valid ? head_err_q : 1'b0;
    assign err_cnt   = err_cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        cnt_d      = cnt_q;
        head_idx_d = head_idx_q;
        head_err_d = head_err_q;
        tail_idx_d = tail_idx_q;
        tail_err_d = tail_err_q;

        if (push && pop) begin
            // Only reachable with cnt=1: the new word replaces the departing head.
            head_idx_d = enc_idx;
            head_err_d = enc_err;
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                head_idx_d = enc_idx;
                head_err_d = enc_err;
            end else begin
                tail_idx_d = enc_idx;
                tail_err_d = enc_err;
            end
            cnt_d = cnt_q + 2'd1;
        end else if (pop) begin
            head_idx_d = tail_idx_q;
            head_err_d = tail_err_q;
            cnt_d      = cnt_q - 2'd1;
        end

        // Clear wins over the old value, but a same-cycle malformed accept still counts.
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = (push && enc_err) ? CntOne : '0;
        end else if (push && enc_err && (err_cnt_q != CntMax)) begin
            err_cnt_d = err_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            head_idx_q <= '0;
            head_err_q <= 1'b0;
            tail_idx_q <= '0;
            tail_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            head_idx_q <= head_idx_d;
            head_err_q <= head_err_d;
            tail_idx_q <= tail_idx_d;
            tail_err_q <= tail_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
module tb_onehot_encoder_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_err;
    logic       err_clr;
    logic [7:0] err_cnt;

    onehot_encoder_stream #(
        .BITS  (3),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vec;
        int         idx;
        bit         err;
    } vec_t;

    typedef struct {
        int idx;
        bit err;
    } exp_t;

    vec_t tbl[8];
    exp_t exp_q[$];
    int   exp_errcnt;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference encoder, written independently from the RTL.
    task automatic ref_enc(input logic [7:0] v, output int idx, output bit err);
        idx = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        err = ($countones(v) != 1);
    endtask

    // One clock: settle, score the handshakes about to occur, then advance.
    task automatic cycle();
        exp_t e;
        exp_t h;
        bit   fire_err;
        #1;
        fire_err = 1'b0;
        if (rst) begin
            exp_q.delete();
            exp_errcnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    h = exp_q.pop_front();
                    chk("sb_idx", int'(out_idx), h.idx);
                    chk("sb_err", int'(out_err), int'(h.err));
                end
            end
            if (in_valid && in_ready) begin
                ref_enc(in_vec, e.idx, e.err);
                exp_q.push_back(e);
                fire_err = e.err;
            end
            if (err_clr) exp_errcnt = fire_err ? 1 : 0;
            else if (fire_err && exp_errcnt < 255) exp_errcnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_errcnt = 0;
        tbl[0] = '{8'h20, 5, 1'b0};
        tbl[1] = '{8'h01, 0, 1'b0};
        tbl[2] = '{8'h80, 7, 1'b0};
        tbl[3] = '{8'h00, 0, 1'b1};
        tbl[4] = '{8'h14, 2, 1'b1};
        tbl[5] = '{8'hFF, 0, 1'b1};
        tbl[6] = '{8'hC0, 6, 1'b1};
        tbl[7] = '{8'h08, 3, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 8'h04;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        @(negedge clk);

        // Reset, with a word offered that must not be taken.
        cycle();
        cycle();
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_out_idx", int'(out_idx), 0);
        chk("post_rst_out_err", int'(out_err), 0);
        chk("post_rst_err_cnt", int'(err_cnt), 0);

        // Table: single word through an empty buffer, one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            in_vec    = tbl[i].vec;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            #1;
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_idx", int'(out_idx), tbl[i].idx);
            chk("tbl_err", int'(out_err), int'(tbl[i].err));
            cycle();
        end
        #1;
        chk("tbl_err_cnt", int'(err_cnt), 4);

        // Backpressure: two pushes fill the buffer, third word is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 8'h01;
        cycle();
        in_vec = 8'h80;
        cycle();
        in_vec = 8'h04;
        #1;
        chk("full_in_ready", int'(in_ready), 0);
        cycle();
        cycle();
        chk("held_in_ready", int'(in_ready), 0);
        chk("held_head_idx", int'(out_idx), 0);
        out_ready = 1'b1;
        cycle();             // pops idx 0, 04 still held
        cycle();             // pops idx 7, pushes 04
        in_valid = 1'b0;
        #1;
        chk("bp_third_idx", int'(out_idx), 2);
        cycle();             // pops idx 2
        chk("bp_drained", int'(out_valid), 0);

        // err_clr alone, then two malformed words.
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        #1;
        chk("clr_err_cnt", int'(err_cnt), 0);
        in_valid = 1'b1;
        in_vec   = 8'h00;
        cycle();
        in_vec = 8'h14;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("malformed_err_cnt", int'(err_cnt), 2);

        // Saturation.
        in_valid = 1'b1;
        in_vec   = 8'h00;
        repeat (260) cycle();
        chk("sat_err_cnt", int'(err_cnt), 255);
        cycle();
        chk("sat_hold_err_cnt", int'(err_cnt), 255);
        err_clr = 1'b1;
        cycle();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_inc_err_cnt", int'(err_cnt), 1);
        chk("clr_inc_model", int'(err_cnt), exp_errcnt);
        cycle();
        chk("sat_drained", int'(out_valid), 0);

        // cnt=1 with simultaneous push and pop.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 8'h10;
        cycle();
        in_valid = 1'b0;
        #1;
        chk("pp_head_before", int'(out_idx), 4);
        in_valid  = 1'b1;
        in_vec    = 8'h40;
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pp_valid", int'(out_valid), 1);
        chk("pp_head_after", int'(out_idx), 6);
        out_ready = 1'b1;
        cycle();
        chk("pp_single_entry", int'(out_valid), 0);

        // Reset with two entries buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 8'h00;
        cycle();
        in_vec = 8'h01;
        cycle();
        in_vec = 8'h02;
        rst    = 1'b1;
        cycle();
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_err_cnt", int'(err_cnt), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("after_rst_in_ready", int'(in_ready), 1);
        chk("after_rst_out_valid", int'(out_valid), 0);
        cycle();
        in_valid = 1'b0;
        #1;
        chk("fresh_valid", int'(out_valid), 1);
        chk("fresh_idx", int'(out_idx), 1);
        chk("fresh_err", int'(out_err), 0);
        cycle();

        chk("final_sb_empty", exp_q.size(), 0);
        chk("final_out_valid", int'(out_valid), 0);
        chk("final_err_cnt", int'(err_cnt), exp_errcnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
